bcd_counter: RTL and testbench
==============================

BCD_COUNTER -- requirements
Module: bcd_counter

Interface
REQ-001 Parameters: none; digit range fixed at 0..9, reset value fixed at 0.
REQ-002 clk  input  1  rising-edge clock; all state changes occur on this edge.
REQ-003 reset  input  1  asynchronous, active-high reset; forces num to 0 immediately, independent of clk.
REQ-004 set0  input  1  synchronous load of 0.
REQ-005 set9  input  1  synchronous load of 9.
REQ-006 up  input  1  count-up enable, sampled each rising edge; also the carry-in from a lower digit.
REQ-007 down  input  1  count-down enable, sampled each rising edge; also the borrow-in from a lower digit.
REQ-008 num  output  4  registered current BCD digit, always within 0..9.
REQ-009 cout  output  1  combinational carry-out to the next digit's up.
REQ-010 bout  output  1  combinational borrow-out to the next digit's down.

Function
REQ-011 Priority at each rising edge (reset low), highest first: set0, set9, up/down, hold.
REQ-012 set0=1: num <= 0, regardless of set9/up/down.
REQ-013 set9=1 and set0=0: num <= 9.
REQ-014 up=1, down=0, no set: num <= num+1 if num<9; num <= 0 if num=9 (wrap).
REQ-015 down=1, up=0, no set: num <= num-1 if num>0; num <= 9 if num=0 (wrap).
REQ-016 up=1 and down=1 together, no set: num holds.
REQ-017 up=0, down=0, no set: num holds.
REQ-018 cout = up & ~down & ~set0 & ~set9 & (num==9); asserted in the same cycle as the 9->0 wrap, so a cascaded upper digit increments on that same edge.
REQ-019 bout = down & ~up & ~set0 & ~set9 & (num==0); asserted in the same cycle as the 0->9 wrap.
REQ-020 cout and bout are never high simultaneously.
REQ-021 Latency: num reflects a set/count one clock edge after sampling; cout/bout have zero latency from inputs and num.
REQ-022 Up held high continuously: num advances every clock edge; cout is high one cycle in ten.
REQ-023 num never takes the values 10..15; if an illegal value is ever present, the next counting edge loads 0.
REQ-024 Chaining: N instances with shared clk/reset/set0/set9 and up/down of digit k tied to cout/bout of digit k-1 form an N-digit synchronous decimal up/down counter.

Reset
REQ-025 reset=1: num=0 asynchronously; cout/bout follow REQ-018/019 with num=0 (bout may be high if down=1).
REQ-026 Reset dominates set0, set9, up and down while asserted; counting resumes on the first rising edge after deassertion.
REQ-027 Reset asserted mid-count clears the digit without waiting for a clock edge.

Verification
REQ-028 reset pulse, then up=1 for 12 edges -> num 1..9,0,1,2; cout high only during the cycle num=9.
REQ-029 4-digit chain from 0000, up=1 for 12 edges -> value 0012; then up=0, down=1 for 13 edges -> 9999 with all bout high in the 0000 cycle.
REQ-030 num=5, set0=1 -> 0 next edge; set9=1 -> 9 next edge; set0=set9=1 -> 0; cout/bout low throughout.
REQ-031 num=9, up=down=1 -> num stays 9, cout=0, bout=0.
REQ-032 num=7 counting up, reset raised between edges -> num=0 before next edge; after release, up=1 -> 1 on first edge.

Source files
------------

// File: rtl/bcd_counter.sv
// Single-digit synchronous BCD up/down counter with load-0/load-9 and
// combinational carry/borrow outputs so digits can be cascaded into a
// multi-digit decimal counter sharing one clock.
module bcd_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       set0,
    input  logic       set9,
    input  logic       up,
    input  logic       down,
    output logic [3:0] num,
    output logic       cout,
    output logic       bout
);

    logic [3:0] num_q;
    logic [3:0] num_d;
    logic       count_up;
    logic       count_down;

    // Counting only happens when exactly one direction is requested and no load is pending.
    assign count_up   = up & ~down & ~set0 & ~set9;
    assign count_down = down & ~up & ~set0 & ~set9;

    // Next digit: load-0 beats load-9 beats counting; illegal codes recover to 0 on a count.
    always_comb begin
        num_d = num_q;
        if (set0) begin
            num_d = 4'd0;
        end else if (set9) begin
            num_d = 4'd9;
        end else if (count_up) begin
            if (num_q >= 4'd9) begin
                num_d = 4'd0;
            end else begin
                num_d = num_q + 4'd1;
            end
        end else if (count_down) begin
            if (num_q == 4'd0) begin
                num_d = 4'd9;
            end else if (num_q > 4'd9) begin
                num_d = 4'd0;
            end else begin
                num_d = num_q - 4'd1;
            end
        end
    end

    // Digit register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q <= 4'd0;
        end else begin
            num_q <= num_d;
        end
    end

    assign num  = num_q;
    // Carry/borrow fire in the same cycle as the wrap so the next digit steps on that edge.
    assign cout = count_up & (num_q == 4'd9);
    assign bout = count_down & (num_q == 4'd0);

endmodule

// File: tb/tb_bcd_counter.sv
module tb_bcd_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       set0, set9, up, down;
    logic [3:0] num;
    logic       cout, bout;

    logic        c_set0, c_set9, c_up, c_down;
    logic [15:0] c_val;
    logic [3:0]  c_cy, c_bw, c_upi, c_dni;

    int n_checks = 0;
    int n_errors = 0;
    int ref_num;
    int ref_tot;

    always #5 clk = ~clk;

    bcd_counter dut (
        .clk(clk), .reset(reset), .set0(set0), .set9(set9),
        .up(up), .down(down), .num(num), .cout(cout), .bout(bout)
    );

    assign c_upi = {c_cy[2:0], c_up};
    assign c_dni = {c_bw[2:0], c_down};

    for (genvar k = 0; k < 4; k++) begin : g_chain
        bcd_counter u_dig (
            .clk(clk), .reset(reset), .set0(c_set0), .set9(c_set9),
            .up(c_upi[k]), .down(c_dni[k]), .num(c_val[4*k +: 4]),
            .cout(c_cy[k]), .bout(c_bw[k])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Decimal behaviour of one digit, straight from the priority rules.
    function automatic int next_digit(int v, bit s0, bit s9, bit u, bit d);
        if (s0) return 0;
        if (s9) return 9;
        if (u && !d) return (v + 1) % 10;
        if (d && !u) return (v + 9) % 10;
        return v;
    endfunction

    // A 4-digit chain behaves as a single modulo-10000 counter.
    function automatic int next_total(int v, bit s0, bit s9, bit u, bit d);
        if (s0) return 0;
        if (s9) return 9999;
        if (u && !d) return (v + 1) % 10000;
        if (d && !u) return (v + 9999) % 10000;
        return v;
    endfunction

    function automatic int bcd_value(logic [15:0] v);
        return int'(v[3:0]) + 10 * int'(v[7:4]) + 100 * int'(v[11:8]) + 1000 * int'(v[15:12]);
    endfunction

    // One clock: drive inputs after negedge, check comb outputs, then check registered state.
    task automatic cycle(input bit s0, input bit s9, input bit u, input bit d,
                         input bit cs0, input bit cs9, input bit cu, input bit cd);
        bit nset, cnset;
        set0 = s0; set9 = s9; up = u; down = d;
        c_set0 = cs0; c_set9 = cs9; c_up = cu; c_down = cd;
        nset  = !s0 && !s9;
        cnset = !cs0 && !cs9;
        #1;
        check("cout", cout, nset && u && !d && ref_num == 9);
        check("bout", bout, nset && d && !u && ref_num == 0);
        check("not_both", cout & bout, 0);
        check("chain_cout", c_cy[3], cnset && cu && !cd && ref_tot == 9999);
        check("chain_bout", c_bw[3], cnset && cd && !cu && ref_tot == 0);
        if (cnset && cd && !cu && ref_tot == 0)
            check("chain_all_bout", c_bw, 4'hF);
        @(posedge clk);
        #1;
        ref_num = next_digit(ref_num, s0, s9, u, d);
        ref_tot = next_total(ref_tot, cs0, cs9, cu, cd);
        check("num", num, ref_num);
        check("num_legal", num <= 9, 1);
        check("chain_val", bcd_value(c_val), ref_tot);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        set0 = 0; set9 = 0; up = 0; down = 1;
        c_set0 = 0; c_set9 = 0; c_up = 0; c_down = 0;
        #2;
        check("rst_num", num, 0);
        check("rst_cout", cout, 0);
        check("rst_bout", bout, 1);
        // Reset dominates loads and counting.
        set9 = 1; up = 1; down = 0; c_set9 = 1; c_up = 1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_dom_num", num, 0);
        check("rst_dom_chain", c_val, 0);
        @(negedge clk);
        reset = 1'b0;
        ref_num = 0;
        ref_tot = 0;

        // Up for 12 edges on the digit and on the chain.
        for (int i = 0; i < 12; i++) cycle(0, 0, 1, 0, 0, 0, 1, 0);
        check("up12_num", num, 2);
        check("up12_chain", bcd_value(c_val), 12);
        // Chain down 13 edges through 0000 to 9999.
        for (int i = 0; i < 13; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
        check("down13_chain", c_val, 16'h9999);

        // Loads from 5.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0, 0, 0, 0);
        check("at5", num, 5);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("set0", num, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("set9", num, 9);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        check("set0_over_set9", num, 0);

        // Up and down together hold, even at 9.
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 0, 0, 0);
        check("updown_hold", num, 9);

        // Asynchronous reset mid-count at 7.
        cycle(1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, 0, 0, 1, 0);
        check("at7", num, 7);
        up = 1; c_up = 1;
        @(posedge clk); #1;
        ref_num = 8; ref_tot = 8;
        check("at8", num, 8);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_num", num, 0);
        check("async_rst_chain", c_val, 0);
        @(negedge clk);
        reset = 1'b0;
        ref_num = 0; ref_tot = 0;
        cycle(0, 0, 1, 0, 0, 0, 1, 0);
        check("after_rst", num, 1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
